// File: rtl/video_timing_gen_if.sv
`default_nettype none
//==============================================================================
// Module   : video_timing_gen_if
// Purpose  : Bundle between a video core and the raster timing generator.
//            The core side (master) supplies the pixel enable, the signed sync
//            offsets and its pixel data. The generator side (slave) returns
//            counters, blanks, syncs, DE, line/frame strobes and blanked RGB.
// Signals  : ce_pix, hoffs[4:0], voffs[2:0], rgb_in[RGB_W]       core -> gen
//            hpos[HW], vpos[VW], hblank, vblank, hsync_n, vsync_n,
//            de, line_start, frame_start, rgb_out[RGB_W]         gen  -> core
// Revision : 1.0  initial release
//==============================================================================
interface video_timing_gen_if #(
    parameter int RGB_W = 8,
    parameter int HW    = 9,
    parameter int VW    = 9
);
    logic             ce_pix;
    logic [4:0]       hoffs;
    logic [2:0]       voffs;
    logic [RGB_W-1:0] rgb_in;
    logic [HW-1:0]    hpos;
    logic [VW-1:0]    vpos;
    logic             hblank;
    logic             vblank;
    logic             hsync_n;
    logic             vsync_n;
    logic             de;
    logic             line_start;
    logic             frame_start;
    logic [RGB_W-1:0] rgb_out;

    modport master (
        output ce_pix, hoffs, voffs, rgb_in,
        input  hpos, vpos, hblank, vblank, hsync_n, vsync_n,
               de, line_start, frame_start, rgb_out
    );

    modport slave (
        input  ce_pix, hoffs, voffs, rgb_in,
        output hpos, vpos, hblank, vblank, hsync_n, vsync_n,
               de, line_start, frame_start, rgb_out
    );
endinterface
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
//==============================================================================
// Module   : video_timing_gen
// Purpose  : Parametrised raster timing generator on clk_sys with a pixel
//            clock-enable. Runtime signed H/V sync offsets are latched at the
//            frame wrap so a frame never tears; sync windows wrap modulo the
//            line/frame period.
// Ports    : clk_sys  system clock (only clock)
//            reset    synchronous, active-high
//            bus      video_timing_gen_if.slave (see interface header)
// Notes    : HW and VW must be at least 6 and 4 so the offset-adjusted sync
//            start fits in the signed sum one bit wider than the counter.
// Revision : 1.0  initial release
//==============================================================================
module video_timing_gen #(
    parameter int H_TOTAL  = 512,
    parameter int H_ACTIVE = 336,
    parameter int HS_START = 360,
    parameter int HS_WIDTH = 24,
    parameter int V_TOTAL  = 262,
    parameter int V_ACTIVE = 240,
    parameter int VS_START = 240,
    parameter int VS_WIDTH = 3,
    parameter int RGB_W    = 8,
    parameter int HW       = 9,
    parameter int VW       = 9
) (
    input wire               clk_sys,
    input wire               reset,
    video_timing_gen_if.slave bus
);

    localparam logic [HW-1:0]        c_h_last   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]        c_v_last   = VW'(V_TOTAL - 1);
    localparam logic signed [HW:0]   c_hs_start = (HW+1)'(HS_START);
    localparam logic signed [VW:0]   c_vs_start = (VW+1)'(VS_START);

    // Elaboration-time parameter sanity
    if (HS_WIDTH < 1 || HS_WIDTH > H_TOTAL - 1) begin : g_hs_width_bad
        $error("video_timing_gen: HS_WIDTH must be in 1..H_TOTAL-1");
    end
    if (VS_WIDTH < 1 || VS_WIDTH > V_TOTAL - 1) begin : g_vs_width_bad
        $error("video_timing_gen: VS_WIDTH must be in 1..V_TOTAL-1");
    end
    if ((2 ** HW) < H_TOTAL || (2 ** VW) < V_TOTAL) begin : g_cnt_width_bad
        $error("video_timing_gen: HW/VW too narrow for H_TOTAL/V_TOTAL");
    end

    logic [HW-1:0]      r_hcnt;
    logic [VW-1:0]      r_vcnt;
    logic signed [4:0]  r_hoffs_l;
    logic signed [2:0]  r_voffs_l;
    logic               r_hblank;
    logic               r_vblank;
    logic               r_hsync_n;
    logic               r_vsync_n;
    logic               r_de;
    logic               r_line_start;
    logic               r_frame_start;
    logic [RGB_W-1:0]   r_rgb;

    logic               w_hwrap;
    logic               w_vwrap;
    logic               w_fwrap;
    logic [HW-1:0]      w_hcnt_nx;
    logic [VW-1:0]      w_vcnt_nx;
    logic signed [4:0]  w_hoffs_eff;
    logic signed [2:0]  w_voffs_eff;
    logic signed [HW:0] w_hs_sum;
    logic signed [VW:0] w_vs_sum;
    int                 w_hs_base;
    int                 w_vs_base;
    int                 w_hs_dist;
    int                 w_vs_dist;
    logic               w_hblank_nx;
    logic               w_vblank_nx;
    logic               w_hsync_n_nx;
    logic               w_vsync_n_nx;

    always_comb begin
        w_hwrap   = (r_hcnt == c_h_last);
        w_vwrap   = (r_vcnt == c_v_last);
        w_fwrap   = w_hwrap && w_vwrap;
        w_hcnt_nx = w_hwrap ? '0 : r_hcnt + 1'b1;
        if (!w_hwrap)
            w_vcnt_nx = r_vcnt;
        else
            w_vcnt_nx = w_vwrap ? '0 : r_vcnt + 1'b1;

        // The pixel that opens a frame already belongs to it, so it must see
        // the offsets being captured on this very enable, not the old latch.
        w_hoffs_eff = w_fwrap ? $signed(bus.hoffs) : r_hoffs_l;
        w_voffs_eff = w_fwrap ? $signed(bus.voffs) : r_voffs_l;

        // Sync start = nominal + offset, reduced to 0..TOTAL-1
        w_hs_sum  = c_hs_start + ((HW+1)'(w_hoffs_eff) <<< 1);
        w_vs_sum  = c_vs_start + (VW+1)'(w_voffs_eff);
        w_hs_base = int'(w_hs_sum) % H_TOTAL;
        if (w_hs_base < 0)
            w_hs_base = w_hs_base + H_TOTAL;
        w_vs_base = int'(w_vs_sum) % V_TOTAL;
        if (w_vs_base < 0)
            w_vs_base = w_vs_base + V_TOTAL;

        // Distance past the sync start, modulo the period, so a window that
        // straddles the wrap is a single comparison.
        w_hs_dist = int'(w_hcnt_nx) - w_hs_base;
        if (w_hs_dist < 0)
            w_hs_dist = w_hs_dist + H_TOTAL;
        w_vs_dist = int'(w_vcnt_nx) - w_vs_base;
        if (w_vs_dist < 0)
            w_vs_dist = w_vs_dist + V_TOTAL;

        w_hsync_n_nx = !(w_hs_dist < HS_WIDTH);
        w_vsync_n_nx = !(w_vs_dist < VS_WIDTH);
        w_hblank_nx  = (int'(w_hcnt_nx) >= H_ACTIVE);
        w_vblank_nx  = (int'(w_vcnt_nx) >= V_ACTIVE);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_hcnt        <= c_h_last;
            r_vcnt        <= c_v_last;
            r_hoffs_l     <= '0;
            r_voffs_l     <= '0;
            r_hblank      <= 1'b1;
            r_vblank      <= 1'b1;
            r_hsync_n     <= 1'b1;
            r_vsync_n     <= 1'b1;
            r_de          <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_rgb         <= '0;
        end else if (bus.ce_pix) begin
            r_hcnt        <= w_hcnt_nx;
            r_vcnt        <= w_vcnt_nx;
            if (w_fwrap) begin
                r_hoffs_l <= $signed(bus.hoffs);
                r_voffs_l <= $signed(bus.voffs);
            end
            r_hblank      <= w_hblank_nx;
            r_vblank      <= w_vblank_nx;
            r_hsync_n     <= w_hsync_n_nx;
            r_vsync_n     <= w_vsync_n_nx;
            r_de          <= !(w_hblank_nx || w_vblank_nx);
            r_line_start  <= w_hwrap;
            r_frame_start <= w_fwrap;
            r_rgb         <= (w_hblank_nx || w_vblank_nx) ? '0 : bus.rgb_in;
        end else begin
            // Strobes are single clk_sys pulses even though state holds
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign bus.hpos        = r_hcnt;
    assign bus.vpos        = r_vcnt;
    assign bus.hblank      = r_hblank;
    assign bus.vblank      = r_vblank;
    assign bus.hsync_n     = r_hsync_n;
    assign bus.vsync_n     = r_vsync_n;
    assign bus.de          = r_de;
    assign bus.line_start  = r_line_start;
    assign bus.frame_start = r_frame_start;
    assign bus.rgb_out     = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_video_timing_gen
// Purpose  : Self-checking bench for video_timing_gen on a small 16x8 raster.
//            A frame-position model (linear pixel index since reset) predicts
//            every output; per-frame masks of sync/blank columns and strobe
//            counts are compared with hand-derived constants.
// Revision : 1.0  initial release
//==============================================================================
module tb_video_timing_gen;
    localparam int HT = 16, HA = 10, HSS = 12, HSW = 2;
    localparam int VT = 8,  VA = 5,  VSS = 6,  VSW = 1;
    localparam int RW = 8,  HWD = 9, VWD = 9;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    video_timing_gen_if #(.RGB_W(RW), .HW(HWD), .VW(VWD)) vif ();

    video_timing_gen #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .HS_START(HSS), .HS_WIDTH(HSW),
        .V_TOTAL(VT), .V_ACTIVE(VA), .VS_START(VSS), .VS_WIDTH(VSW),
        .RGB_W(RW), .HW(HWD), .VW(VWD)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (vif)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: position index within the frame, offsets in force
    int m_pos, m_hoff, m_voff;
    int e_hpos, e_vpos, e_hb, e_vb, e_hs, e_vs, e_de, e_ls, e_fs, e_rgb;

    // Per-frame observations taken from the DUT
    bit acc_valid = 0;
    int fr_done = 0;
    int acc_ce, acc_ls;
    logic [15:0] acc_hs, acc_hb;
    logic [7:0]  acc_vs;
    int last_ce, last_ls;
    logic [15:0] last_hs, last_hb;
    logic [7:0]  last_vs;
    int strobe_cnt;

    function automatic int pmod(int a, int m);
        return ((a % m) + m) % m;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(bit rst, bit ce, logic [4:0] ho, logic [2:0] vo, logic [7:0] rgb);
        int h, v;
        if (rst) begin
            m_pos = HT*VT - 1; m_hoff = 0; m_voff = 0;
            e_hpos = HT-1; e_vpos = VT-1; e_hb = 1; e_vb = 1; e_hs = 1; e_vs = 1;
            e_de = 0; e_ls = 0; e_fs = 0; e_rgb = 0;
        end else if (ce) begin
            m_pos = (m_pos + 1) % (HT*VT);
            h = m_pos % HT;
            v = m_pos / HT;
            if (m_pos == 0) begin
                m_hoff = int'($signed(ho));
                m_voff = int'($signed(vo));
            end
            e_hpos = h; e_vpos = v;
            e_ls = (h == 0); e_fs = (m_pos == 0);
            e_hb = (h >= HA); e_vb = (v >= VA);
            e_hs = (pmod(h - pmod(HSS + 2*m_hoff, HT), HT) < HSW) ? 0 : 1;
            e_vs = (pmod(v - pmod(VSS + m_voff, VT), VT) < VSW) ? 0 : 1;
            e_de = !(e_hb || e_vb);
            e_rgb = e_de ? int'(rgb) : 0;
        end else begin
            e_ls = 0; e_fs = 0;
        end
    endtask

    task automatic step();
        bit rs, ce; logic [4:0] ho; logic [2:0] vo; logic [7:0] rg;
        rs = reset; ce = vif.ce_pix; ho = vif.hoffs; vo = vif.voffs; rg = vif.rgb_in;
        @(posedge clk_sys); #1;
        model(rs, ce, ho, vo, rg);
        chk("hpos",        32'(vif.hpos),        32'(e_hpos));
        chk("vpos",        32'(vif.vpos),        32'(e_vpos));
        chk("hblank",      32'(vif.hblank),      32'(e_hb));
        chk("vblank",      32'(vif.vblank),      32'(e_vb));
        chk("hsync_n",     32'(vif.hsync_n),     32'(e_hs));
        chk("vsync_n",     32'(vif.vsync_n),     32'(e_vs));
        chk("de",          32'(vif.de),          32'(e_de));
        chk("line_start",  32'(vif.line_start),  32'(e_ls));
        chk("frame_start", 32'(vif.frame_start), 32'(e_fs));
        chk("rgb_out",     32'(vif.rgb_out),     32'(e_rgb));
        if (vif.line_start || vif.frame_start) strobe_cnt++;
        if (rs) begin
            acc_valid = 0;
        end else if (ce) begin
            if (vif.frame_start) begin
                if (acc_valid) begin
                    last_ce = acc_ce; last_ls = acc_ls;
                    last_hs = acc_hs; last_hb = acc_hb; last_vs = acc_vs;
                    fr_done++;
                end
                acc_valid = 1; acc_ce = 0; acc_ls = 0;
                acc_hs = '0; acc_hb = '0; acc_vs = '0;
            end
            if (acc_valid) begin
                acc_ce++;
                if (vif.line_start) acc_ls++;
                if (!vif.hsync_n) acc_hs[vif.hpos[3:0]] = 1'b1;
                if (vif.hblank)   acc_hb[vif.hpos[3:0]] = 1'b1;
                if (!vif.vsync_n) acc_vs[vif.vpos[2:0]] = 1'b1;
            end
        end
    endtask

    // One pixel: ce_pix high for one clk, low for the next
    task automatic pix();
        vif.ce_pix = 1'b1;
        vif.rgb_in = 8'($urandom);
        step();
        vif.ce_pix = 1'b0;
        step();
    endtask

    task automatic run_frames(int n);
        int target;
        target = fr_done + n;
        for (int i = 0; i < n*300 && fr_done < target; i++) pix();
        chk("frame_wait", 32'(fr_done), 32'(target));
    endtask

    initial begin
        vif.ce_pix = 1'b0; vif.hoffs = '0; vif.voffs = '0; vif.rgb_in = '0;
        reset = 1'b1;
        repeat (3) step();
        chk("rst_hpos", 32'(vif.hpos), 32'(HT-1));
        chk("rst_vpos", 32'(vif.vpos), 32'(VT-1));
        chk("rst_de",   32'(vif.de),   32'(0));
        reset = 1'b0;
        step();

        // First enable after reset lands on (0,0) with both strobes
        vif.ce_pix = 1'b1; vif.rgb_in = 8'h5A;
        step();
        chk("first_hpos", 32'(vif.hpos), 32'(0));
        chk("first_vpos", 32'(vif.vpos), 32'(0));
        chk("first_fs",   32'(vif.frame_start), 32'(1));
        chk("first_de",   32'(vif.de), 32'(1));
        chk("first_rgb",  32'(vif.rgb_out), 32'(8'h5A));
        chk("first_hs",   32'(vif.hsync_n), 32'(1));
        chk("first_vs",   32'(vif.vsync_n), 32'(1));
        vif.ce_pix = 1'b0;
        step();
        chk("fs_one_clk", 32'(vif.frame_start), 32'(0));

        // Nominal geometry
        run_frames(1);
        chk("frame_ce",   32'(last_ce), 32'(128));
        chk("frame_ls",   32'(last_ls), 32'(8));
        chk("hblank_map", 32'(last_hb), 32'(16'hFC00));
        chk("hs_nominal", 32'(last_hs), 32'(16'h3000));
        chk("vs_nominal", 32'(last_vs), 32'(8'h40));

        // Mid-frame hoffs change takes effect only from the next frame
        repeat (60) pix();
        vif.hoffs = 5'sd2;
        run_frames(1);
        chk("hs_midframe", 32'(last_hs), 32'(16'h3000));
        run_frames(1);
        chk("hs_plus2",    32'(last_hs), 32'(16'h0003));

        vif.hoffs = 5'h1F;
        run_frames(2);
        chk("hs_minus1",   32'(last_hs), 32'(16'h0C00));

        vif.hoffs = '0; vif.voffs = 3'b100;
        run_frames(2);
        chk("vs_minus4",   32'(last_vs), 32'(8'h04));
        vif.voffs = 3'd3;
        run_frames(2);
        chk("vs_plus3",    32'(last_vs), 32'(8'h02));
        chk("hs_back0",    32'(last_hs), 32'(16'h3000));
        vif.voffs = '0;

        // Enable held low: no strobes, outputs held (model checks hold)
        repeat (37) pix();
        strobe_cnt = 0;
        vif.ce_pix = 1'b0;
        repeat (5) step();
        chk("ce_low_strobes", 32'(strobe_cnt), 32'(0));

        // Reset in the middle of the frame at (7,3)
        for (int i = 0; i < 300 && !(e_hpos == 7 && e_vpos == 3); i++) pix();
        chk("reach_h", 32'(vif.hpos), 32'(7));
        chk("reach_v", 32'(vif.vpos), 32'(3));
        reset = 1'b1;
        step();
        chk("midrst_hpos", 32'(vif.hpos), 32'(HT-1));
        chk("midrst_hs",   32'(vif.hsync_n), 32'(1));
        reset = 1'b0;
        vif.ce_pix = 1'b1;
        step();
        chk("resume_hpos", 32'(vif.hpos), 32'(0));
        chk("resume_vpos", 32'(vif.vpos), 32'(0));
        chk("resume_fs",   32'(vif.frame_start), 32'(1));
        vif.ce_pix = 1'b0;
        step();

        // Randomised traffic: irregular enables, offsets changed at random
        // times, occasional resets; the model predicts every output.
        for (int i = 0; i < 2500; i++) begin
            vif.ce_pix = ($urandom_range(0, 2) != 0);
            vif.rgb_in = 8'($urandom);
            if ($urandom_range(0, 149) == 0) vif.hoffs = 5'($urandom);
            if ($urandom_range(0, 149) == 0) vif.voffs = 3'($urandom);
            reset = ($urandom_range(0, 799) == 0);
            step();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
